spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_peripheral.sv | 68 ++++++
 tb/tb_spi_peripheral.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI write-only register file decoding 16-bit frames into five 8-bit control registers.
module spi_peripheral #(
  parameter logic [6:0] MAX_ADDR = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync_nCS,
  input  logic       sync_COPI,
  input  logic       sync_SCLK,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_valid
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_nxt;
  logic ncs_q, sclk_q;
  logic [15:0] shreg;
  logic [4:0] cnt;
  logic [7:0] regs [0:4];
  logic sclk_rise, ncs_fall, ncs_rise;
  logic do_clear, do_shift, do_write;
  assign sclk_rise = !sclk_q && sync_SCLK;
  assign ncs_fall = ncs_q && !sync_nCS;
  assign ncs_rise = !ncs_q && sync_nCS;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (ncs_fall ? SHIFT : IDLE) :
                state == SHIFT ? (ncs_rise ? COMMIT : SHIFT) : IDLE;
  // An SCLK edge coincident with the closing nCS edge does not count as a bit.
  always_comb begin
    do_clear = state == IDLE && ncs_fall;
    do_shift = state == SHIFT && sclk_rise && !ncs_rise;
    do_write = state == COMMIT && cnt == 5'd16 && shreg[15] && shreg[14:8] <= MAX_ADDR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_q <= 1'b0;
      sclk_q <= 1'b0;
      shreg <= '0;
      cnt <= '0;
      txn_valid <= 1'b0;
      for (int i = 0; i < 5; i++) regs[i] <= '0;
    end else begin
      ncs_q <= sync_nCS;
      sclk_q <= sync_SCLK;
      txn_valid <= do_write;
      if (do_clear) begin
        shreg <= '0;
        cnt <= '0;
      end else if (do_shift) begin
        shreg <= {shreg[14:0], sync_COPI};
        cnt <= cnt == 5'd17 ? 5'd17 : cnt + 5'd1;
      end
      for (int i = 0; i < 5; i++)
        if (do_write && shreg[14:8] == 7'(i)) regs[i] <= shreg[7:0];
    end
  end
  assign en_reg_out_7_0 = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0 = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle = regs[4];
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: table vectors, timing corner sequences and random frames against a register-array model.
module tb_spi_peripheral;
  logic clk = 0, rst, ncs, copi, sclk;
  logic [7:0] r0, r1, r2, r3, r4;
  logic txn_valid;
  int checks = 0, errors = 0, tv_count = 0;
  logic [7:0] m [0:4];
  spi_peripheral dut (
    .clk(clk), .rst(rst), .sync_nCS(ncs), .sync_COPI(copi), .sync_SCLK(sclk),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .txn_valid(txn_valid)
  );
  always #50 clk = ~clk;
  always @(negedge clk) if (txn_valid) tv_count++;
  typedef struct {
    logic [16:0] v;
    int n;
    logic [39:0] exp_regs;
    int exp_pulses;
  } vec_t;
  vec_t vecs [6];
  function automatic logic [39:0] dut_regs();
    return {r4, r3, r2, r1, r0};
  endfunction
  function automatic logic [39:0] model_regs();
    return {m[4], m[3], m[2], m[1], m[0]};
  endfunction
  function automatic void model_clear();
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
  endfunction
  function automatic int model_apply(input logic [16:0] v, input int n);
    if (n == 16 && v[15] && v[14:8] <= 7'd4) begin
      m[v[14:8]] = v[7:0];
      return 1;
    end
    return 0;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic cs_fall();
    @(negedge clk) ncs = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    int h;
    h = $urandom_range(1, 3);
    copi = b;
    repeat (h) @(negedge clk);
    sclk = 1;
    repeat (h) @(negedge clk);
    sclk = 0;
  endtask
  task automatic cs_rise(input int gap);
    @(negedge clk) ncs = 1;
    repeat (gap) @(negedge clk);
  endtask
  task automatic send_frame(input logic [16:0] v, input int n, input int gap);
    cs_fall();
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    cs_rise(gap);
  endtask
  initial begin
    int p0, pe, n;
    logic [16:0] v;
    vecs[0] = '{17'h080F0, 16, 40'h00_00_00_00_F0, 1};
    vecs[1] = '{17'h08480, 16, 40'h80_00_00_00_F0, 1};
    vecs[2] = '{17'h004A5, 16, 40'h80_00_00_00_F0, 0};
    vecs[3] = '{17'h085FF, 16, 40'h80_00_00_00_F0, 0};
    vecs[4] = '{17'h04155, 15, 40'h80_00_00_00_F0, 0};
    vecs[5] = '{17'h104AB, 17, 40'h80_00_00_00_F0, 0};
    rst = 1; ncs = 1; copi = 0; sclk = 0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_regs", dut_regs(), 0);
    chk("reset_txn", txn_valid, 0);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("false_rise_regs", dut_regs(), 0);
    chk("false_rise_pulses", tv_count, 0);
    for (int i = 0; i < 6; i++) begin
      p0 = tv_count;
      send_frame(vecs[i].v, vecs[i].n, 4);
      chk($sformatf("vec%0d_regs", i), dut_regs(), vecs[i].exp_regs);
      chk($sformatf("vec%0d_pulses", i), tv_count - p0, vecs[i].exp_pulses);
      void'(model_apply(vecs[i].v, vecs[i].n));
    end
    // Commit latency: rise seen at edge N, write and pulse after N+1, pulse gone after N+2.
    cs_fall();
    v = 17'h08333;
    for (int i = 15; i >= 0; i--) send_bit(v[i]);
    @(negedge clk) ncs = 1;
    @(posedge clk) #1;
    chk("lat_n_txn", txn_valid, 0);
    chk("lat_n_reg", r3, 8'h00);
    @(posedge clk) #1;
    chk("lat_n1_txn", txn_valid, 1);
    chk("lat_n1_reg", r3, 8'h33);
    @(posedge clk) #1;
    chk("lat_n2_txn", txn_valid, 0);
    void'(model_apply(v, 16));
    repeat (3) @(negedge clk);
    // SCLK rise coincident with nCS rise must not become a 17th bit.
    p0 = tv_count;
    cs_fall();
    v = 17'h08144;
    for (int i = 15; i >= 0; i--) send_bit(v[i]);
    @(negedge clk) begin ncs = 1; sclk = 1; end
    repeat (2) @(negedge clk);
    sclk = 0;
    repeat (3) @(negedge clk);
    chk("coincide_reg", r1, 8'h44);
    chk("coincide_pulses", tv_count - p0, 1);
    void'(model_apply(v, 16));
    // Back-to-back writes with two idle clocks between frames.
    p0 = tv_count;
    send_frame(17'h08111, 16, 2);
    send_frame(17'h08222, 16, 4);
    chk("b2b_r1", r1, 8'h11);
    chk("b2b_r2", r2, 8'h22);
    chk("b2b_pulses", tv_count - p0, 2);
    void'(model_apply(17'h08111, 16));
    void'(model_apply(17'h08222, 16));
    // Reset in the middle of a frame aborts it.
    p0 = tv_count;
    cs_fall();
    v = 17'h083AA;
    for (int i = 15; i >= 8; i--) send_bit(v[i]);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("midrst_regs", dut_regs(), 0);
    chk("midrst_txn", txn_valid, 0);
    rst = 0;
    model_clear();
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    cs_rise(4);
    chk("midrst_after_regs", dut_regs(), 0);
    chk("midrst_after_pulses", tv_count - p0, 0);
    p0 = tv_count;
    send_frame(v, 16, 4);
    chk("postrst_r3", r3, 8'hAA);
    chk("postrst_regs", dut_regs(), 40'h00_AA_00_00_00);
    chk("postrst_pulses", tv_count - p0, 1);
    void'(model_apply(v, 16));
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 4) == 0 ? 15 : ($urandom_range(0, 4) == 0 ? 17 : 16);
      v = 17'($urandom);
      v[14:8] = 7'($urandom_range(0, 7));
      v[15] = $urandom_range(0, 3) != 0;
      if (n == 17) v[16:1] = v[15:0];
      p0 = tv_count;
      send_frame(v, n, $urandom_range(3, 5));
      pe = model_apply(v, n);
      chk($sformatf("rand%0d_regs", k), dut_regs(), model_regs());
      chk($sformatf("rand%0d_pulses", k), tv_count - p0, pe);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
